fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the team's 16x8 single-clock FIFO memory. It tracks occupancy from the writer's write-enable, drives the memory read enable, and absorbs the memory's one-cycle registered read latency in a 2-entry skid buffer. Read data is presented to the consumer on a valid/ready stream. It also returns full/empty/overflow status to the write side.

Parameters:
DATA_WIDTH, 8, stream and memory data width
DATA_DEPTH, 16, memory depth; must equal 2**UP_BIT
UP_BIT, 4, memory address width; occupancy width is UP_BIT+1

Ports:
i_clk  in  1  clock; all logic on posedge
i_rest  in  1  synchronous active-high reset; the same reset that drives the FIFO memory
i_wen  in  1  tap of the writer's write enable to the memory
i_mem_data  in  DATA_WIDTH  registered read data from the memory, valid the cycle after o_ren
o_ren  out  1  memory read enable
o_valid  out  1  stream data valid
i_ready  in  1  consumer ready
o_data  out  DATA_WIDTH  stream data
o_count  out  UP_BIT+1  entries resident in memory (skid buffer contents and in-flight read excluded)
o_full  out  1  o_count == DATA_DEPTH
o_empty  out  1  o_count == 0
o_ovf  out  1  sticky overflow flag

Behaviour:
- Single clock (i_clk). Reset is synchronous and active-high (i_rest).
- Reset values: o_count=0, o_empty=1, o_full=0, o_ovf=0, o_valid=0, o_data=0, skid buffer empty, in-flight flag=0. o_ren is forced to 0 while i_rest=1.
- Reset mid-operation discards the buffered word and any in-flight read. It relies on the memory pointers resetting on the same edge.
- Pop is defined as o_valid & i_ready. o_data is held stable while o_valid=1 and i_ready=0.
- o_ren is combinational: o_ren = !o_empty & (buf_cnt + inflight - pop < 2). It depends on registered state and i_ready.
- inflight is registered: it takes the value of o_ren at each edge. When inflight=1, i_mem_data is written into the skid buffer at the next edge.
- o_count next value = o_count + (i_wen & !o_full) - o_ren.
- Overflow: i_wen while o_full=1 sets o_ovf, regardless of o_ren in the same cycle. The memory overwrites an unread slot; o_count stays at DATA_DEPTH. o_ovf clears only on reset.
- Simultaneous i_wen and o_ren when not full: o_count is unchanged.
- i_wen while empty: no read in that cycle. The earliest o_ren is in the next cycle.
- First-word latency: i_wen in cycle 0 gives o_ren in cycle 1, i_mem_data valid in cycle 2, o_valid=1 in cycle 3.
- Throughput: with i_ready held high and data available, one word per cycle.
- Ordering: strict FIFO order.
- Pointer wrap at DATA_DEPTH is implicit in the memory's UP_BIT-wide pointers; o_count is the sole full/empty authority.
- Skid buffer: 2 entries, registered output, no combinational path from i_mem_data to o_data.

Optional Feature:
FIFO_RD_PTR_CHECK_EN:
- Defined: adds input i_addrr (UP_BIT) from the memory, plus an internal shadow read pointer that increments modulo DATA_DEPTH on each o_ren.
  - Output o_ptr_err (sticky, reset 0) sets if i_addrr differs from the shadow pointer in any cycle after reset.
- Undefined: the port, the shadow pointer and o_ptr_err do not exist; functional behaviour is otherwise identical.

Decomposition:
- Shared header fifo_defs.vh holds the DATA_WIDTH/DATA_DEPTH/UP_BIT defaults and the count-width constant (UP_BIT+1). Both fifo_mem users and fifo_rd_ctrl include it.
- One natural sub-module, fifo_skid_buf: 2-entry valid/ready buffer with push, pop, buf_cnt and registered data out.
- Top level holds the occupancy counter, o_ren logic, in-flight tracking and flags.

Test Plan:
- Reset, then a single write of 8'hA5 with i_ready=1 -> o_ren in cycle 1, o_valid=1 with o_data=8'hA5 in cycle 3, o_empty=1 afterwards.
- Write 16 words 0x00..0x0F with i_ready=0 -> o_count settles at 14 (2 words in the skid buffer) and o_full=0. Write 2 more -> o_count=16, o_full=1. A 17th write -> o_ovf=1, o_count stays 16.
- Burst of 16 words with i_ready=1 throughout -> 16 consecutive o_valid cycles, data 0x00..0x0F in order, no bubbles after the first word.
- Toggle i_ready 1,0,0,1 during a stream -> o_data held while stalled, no word lost or duplicated, o_ren never asserted when buf_cnt+inflight-pop would exceed 1.
- Assert i_rest for one cycle with 5 words resident and 1 in flight -> next cycle o_count=0, o_valid=0, o_ren=0. A subsequent write of 8'h3C is delivered first.
- With FIFO_RD_PTR_CHECK_EN defined, force i_addrr off by one -> o_ptr_err=1 and it stays set until reset.

Source files
------------

// File: rtl/fifo_rd_ctrl_pkg.sv
// fifo_rd_ctrl_pkg
// Shared defaults for the 16x8 single-clock FIFO and its read-side
// controller. The memory and fifo_rd_ctrl both take their parameter
// defaults from here so the two sides cannot drift apart.
//   FIFO_DATA_WIDTH : stream / memory data width
//   FIFO_DATA_DEPTH : memory depth, always 2**FIFO_UP_BIT
//   FIFO_UP_BIT     : memory address width
//   cnt_width()     : occupancy counter width (address width + 1, so that
//                     a completely full memory is representable)
package fifo_rd_ctrl_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_UP_BIT     = 4;
  localparam int FIFO_DATA_DEPTH = 16;

  function automatic int cnt_width(input int up_bit);
    return up_bit + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_skid_buf.sv
// fifo_rd_ctrl_skid_buf
// Two-entry skid buffer that absorbs the memory's one-cycle read latency.
// The output word is taken straight from a register (r_head), so there is
// no combinational path from i_push_data to o_data.
//
// Handshake: a word leaves when o_valid & i_pop (the caller only asserts
// i_pop while o_valid is high). o_data is stable while o_valid=1 and no pop.
// The caller guarantees no push arrives while the buffer holds two words
// and is not being popped in the same cycle.
//
// Ports:
//   i_clk       clock, posedge
//   i_rest      synchronous active-high reset, empties the buffer
//   i_push      write i_push_data into the buffer this edge
//   i_push_data incoming word
//   i_pop       consumer takes the head word this edge
//   o_valid     head word valid
//   o_data      head word (registered)
//   o_cnt       number of words held (0..2)
module fifo_rd_ctrl_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rest,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_cnt
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [1:0]            r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      r_head <= '0;
      r_hold <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head <= i_push_data;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          case ({i_push, i_pop})
            2'b10: begin
              r_hold <= i_push_data;
              r_cnt  <= 2'd2;
            end
            2'b11: r_head <= i_push_data;  // pass-through, count unchanged
            2'b01: r_cnt  <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (i_pop) begin
            // Second entry moves up; a simultaneous push refills it.
            r_head <= r_hold;
            if (i_push) r_hold <= i_push_data;
            else        r_cnt  <= 2'd1;
          end
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-side controller for the 16x8 single-clock FIFO memory. Tracks the
// number of words resident in the memory from the writer's write-enable
// tap, issues memory reads, and lands the registered read data in a
// two-entry skid buffer that feeds a valid/ready stream.
//
// Handshake: a word transfers on the consumer side when o_valid & i_ready.
// o_data is held stable while o_valid=1 and i_ready=0.
//
// Optional build macro FIFO_RD_PTR_CHECK_EN: adds i_addrr (the memory's
// read pointer) and o_ptr_err, a sticky flag set when that pointer ever
// disagrees with a shadow pointer advanced on each o_ren.
//
// Ports:
//   i_clk      clock, posedge
//   i_rest     synchronous active-high reset (shared with the memory)
//   i_wen      tap of the writer's memory write enable
//   i_mem_data registered memory read data, valid the cycle after o_ren
//   o_ren      memory read enable (combinational)
//   o_valid    stream valid
//   i_ready    stream ready
//   o_data     stream data
//   o_count    words resident in memory (buffer and in-flight excluded)
//   o_full     o_count == DATA_DEPTH
//   o_empty    o_count == 0
//   o_ovf      sticky overflow (write while full)
//   i_addrr    [FIFO_RD_PTR_CHECK_EN] memory read pointer
//   o_ptr_err  [FIFO_RD_PTR_CHECK_EN] sticky pointer mismatch flag
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DATA_DEPTH = FIFO_DATA_DEPTH,  // must equal 2**UP_BIT
  parameter int UP_BIT     = FIFO_UP_BIT
) (
  input  logic                  i_clk,
  input  logic                  i_rest,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_ren,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [UP_BIT:0]       o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_ovf
`ifdef FIFO_RD_PTR_CHECK_EN
  ,
  input  logic [UP_BIT-1:0]     i_addrr,
  output logic                  o_ptr_err
`endif
);

  localparam int CNT_W = cnt_width(UP_BIT);

  logic [CNT_W-1:0] r_count;
  logic             r_inflight;
  logic             r_ovf;

  logic [1:0]       w_buf_cnt;
  logic             w_pop;
  logic             w_wen_acc;
  logic             w_ren;
  logic [2:0]       w_occ;

  assign o_full  = (r_count == CNT_W'(DATA_DEPTH));
  assign o_empty = (r_count == '0);

  assign w_pop     = o_valid & i_ready;
  assign w_wen_acc = i_wen & ~o_full;

  // Words already committed to the skid buffer: held plus the one in flight.
  // A read is only issued if, after this cycle's pop, that total stays below
  // two, so the buffer can never be asked to take a third word.
  assign w_occ = {1'b0, w_buf_cnt} + {2'b00, r_inflight};
  assign w_ren = ~i_rest & ~o_empty & (w_occ < (3'd2 + {2'b00, w_pop}));
  assign o_ren = w_ren;

  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      // A write while full is dropped from the count: the memory overwrites
      // an unread slot, so the occupancy cannot grow past DATA_DEPTH.
      r_count    <= r_count + CNT_W'(w_wen_acc) - CNT_W'(w_ren);
      r_inflight <= w_ren;
      if (i_wen & o_full) r_ovf <= 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

  // The in-flight read's data arrives on i_mem_data one cycle after o_ren.
  fifo_rd_ctrl_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rest      (i_rest),
    .i_push      (r_inflight),
    .i_push_data (i_mem_data),
    .i_pop       (w_pop),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_cnt       (w_buf_cnt)
  );

`ifdef FIFO_RD_PTR_CHECK_EN
  logic [UP_BIT-1:0] r_shadow_ptr;
  logic              r_ptr_err;

  // The shadow pointer resets on the same edge as the memory's read
  // pointer, so the two must agree in every non-reset cycle.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      r_shadow_ptr <= '0;
      r_ptr_err    <= 1'b0;
    end else begin
      if (w_ren) r_shadow_ptr <= r_shadow_ptr + 1'b1;
      if (i_addrr != r_shadow_ptr) r_ptr_err <= 1'b1;
    end
  end

  assign o_ptr_err = r_ptr_err;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
// Directed bench for fifo_rd_ctrl. A behavioural 16x8 memory with
// registered read data sits beside the DUT. Inputs change 1 time unit
// after posedge; all outputs are sampled on negedge. A negedge monitor
// checks popped words against exp_q, o_data stability during stalls and
// that o_ren never over-commits the skid buffer.
module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int UB    = 4;

  logic          clk = 1'b0;
  logic          i_rest = 1'b1;
  logic          i_wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] mem_q;
  logic          o_ren, o_valid, o_full, o_empty, o_ovf;
  logic [DW-1:0] o_data;
  logic [UB:0]   o_count;

  int checks = 0;
  int failures = 0;
  int n_pops = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [UB-1:0] wptr, rptr;
  int            tb_occ;

  always @(posedge clk) begin
    if (i_rest) begin
      wptr   <= '0;
      rptr   <= '0;
      mem_q  <= '0;
      tb_occ <= 0;
    end else begin
      if (i_wen) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (o_ren) begin
        mem_q <= mem[rptr];
        rptr  <= rptr + 1'b1;
      end
      tb_occ <= tb_occ + (o_ren ? 1 : 0) - ((o_valid && i_ready) ? 1 : 0);
    end
  end

`ifdef FIFO_RD_PTR_CHECK_EN
  logic          flip = 1'b0;
  logic [UB-1:0] i_addrr;
  logic          o_ptr_err;
  assign i_addrr = rptr ^ {{(UB-1){1'b0}}, flip};
`endif

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH),
    .UP_BIT     (UB)
  ) dut (
    .i_clk      (clk),
    .i_rest     (i_rest),
    .i_wen      (i_wen),
    .i_mem_data (mem_q),
    .o_ren      (o_ren),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_ovf      (o_ovf)
`ifdef FIFO_RD_PTR_CHECK_EN
    ,
    .i_addrr    (i_addrr),
    .o_ptr_err  (o_ptr_err)
`endif
  );

  // ---------------- monitor / scoreboard ----------------
  logic          hold_chk = 1'b0;
  logic [DW-1:0] held = '0;

  always @(negedge clk) begin
    if (i_rest) begin
      hold_chk <= 1'b0;
    end else begin
      if (hold_chk) begin
        checks = checks + 1;
        if (!o_valid || o_data !== held) begin
          failures = failures + 1;
          $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h", o_valid, o_data, held);
        end
      end
      if (o_ren) begin
        checks = checks + 1;
        if (tb_occ - ((o_valid && i_ready) ? 1 : 0) >= 2) begin
          failures = failures + 1;
          $display("FAIL ren_overcommit: occ=%0d pop=%0b with o_ren=1, required occ-pop<2", tb_occ, o_valid && i_ready);
        end
      end
      if (o_valid && i_ready) begin
        checks = checks + 1;
        n_pops = n_pops + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL pop_unexpected: data=%h popped with no word expected", o_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (o_data !== e) begin
            failures = failures + 1;
            $display("FAIL pop_data: got %h required %h", o_data, e);
          end
        end
      end
      hold_chk <= o_valid && !i_ready;
      held     <= o_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic wen, input logic [DW-1:0] d, input logic rdy, input logic sb);
    @(posedge clk);
    #1;
    i_wen   = wen;
    wdata   = d;
    i_ready = rdy;
    if (wen && sb) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    i_rest  = 1'b1;
    i_wen   = 1'b0;
    i_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    i_rest = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_ren",   32'(o_ren),   32'd0);
  endtask

  task automatic test_single();
    step(1'b1, 8'hA5, 1'b1, 1'b1);          // cycle 0
    chk("single_c0_ren", 32'(o_ren), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);          // cycle 1
    chk("single_c1_ren", 32'(o_ren), 32'd1);
    chk("single_c1_count", 32'(o_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);          // cycle 2
    chk("single_c2_valid", 32'(o_valid), 32'd0);
    chk("single_c2_ren", 32'(o_ren), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);          // cycle 3
    chk("single_c3_valid", 32'(o_valid), 32'd1);
    chk("single_c3_data", 32'(o_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);          // cycle 4
    chk("single_c4_valid", 32'(o_valid), 32'd0);
    chk("single_c4_empty", 32'(o_empty), 32'd1);
  endtask

  task automatic test_fill_ovf();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill16_count", 32'(o_count), 32'd14);
    chk("fill16_full", 32'(o_full), 32'd0);
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill18_count", 32'(o_count), 32'd16);
    chk("fill18_full", 32'(o_full), 32'd1);
    chk("fill18_ovf", 32'(o_ovf), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);          // write while full
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_set", 32'(o_ovf), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(o_ovf), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(o_ovf), 32'd0);
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    int first = -1;
    int last = -1;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      step(c < 16, 8'(c), 1'b1, 1'b1);
      if (o_valid) begin
        n_valid++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("b2b_n_valid", 32'(n_valid), 32'd16);
    chk("b2b_first", 32'(first), 32'd3);
    chk("b2b_last", 32'(last), 32'd18);
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    int p0;
    pat = 4'b1001;                            // ready 1,0,0,1 (bit 0 first)
    do_reset();
    p0 = n_pops;
    for (int c = 0; c < 40; c++)
      step(c < 6, 8'(8'h40 + c), pat[c % 4], 1'b1);
    chk("stall_pops", 32'(n_pops - p0), 32'd6);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) step(1'b1, 8'(8'h50 + c), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_count6", 32'(o_count), 32'd6);
    step(1'b0, 8'h00, 1'b1, 1'b0);          // one pop frees a slot
    chk("mid_pop_ren", 32'(o_ren), 32'd1);
    @(posedge clk);
    #1;
    i_rest  = 1'b1;
    i_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_count5", 32'(o_count), 32'd5);
    chk("mid_ren_forced", 32'(o_ren), 32'd0);
    @(posedge clk);
    #1;
    i_rest = 1'b0;
    @(negedge clk);
    chk("mid_after_count", 32'(o_count), 32'd0);
    chk("mid_after_valid", 32'(o_valid), 32'd0);
    chk("mid_after_ren", 32'(o_ren), 32'd0);
    step(1'b1, 8'h3C, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (o_valid && !seen) begin
        seen = 1'b1;
        chk("mid_first_word", 32'(o_data), 32'h3C);
      end
    end
    chk("mid_word_seen", 32'(seen), 32'd1);
  endtask

`ifdef FIFO_RD_PTR_CHECK_EN
  task automatic test_ptr_check();
    do_reset();
    for (int c = 0; c < 9; c++) step(c < 3, 8'(8'h70 + c), 1'b1, 1'b1);
    chk("ptr_ok", 32'(o_ptr_err), 32'd0);
    @(posedge clk);
    #1;
    flip = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    flip = 1'b0;
    @(negedge clk);
    chk("ptr_err_set", 32'(o_ptr_err), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ptr_err_sticky", 32'(o_ptr_err), 32'd1);
    do_reset();
    chk("ptr_err_reset", 32'(o_ptr_err), 32'd0);
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_fill_ovf();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef FIFO_RD_PTR_CHECK_EN
    test_ptr_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
